// File: rtl/display_page_scheduler.sv
// display_page_scheduler
// Drives the page select of the four-page seven-segment display mux. Pages
// advance on a debounced "next" key press or, in auto mode, when the dwell
// timer expires. Invalid pages are skipped, and every page change blanks the
// drivers for BLANK_CYCLES cycles.
//
// Ports:
//   clk, rst_n   display clock, asynchronous active-low reset
//   key_next     raw active-low pushbutton, press = manual advance
//   key_mode     raw active-low pushbutton, press = toggle auto_mode
//   page_valid   bit i high = page i selectable
//   freeze       pauses the dwell counter
//   sel          page select to the display mux
//   blank        display drivers forced off
//   page_change  one-cycle pulse when sel changes
//   auto_mode    1 = auto-rotate, 0 = manual
module display_page_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DWELL_CYCLES    = 100000000,
  parameter int unsigned BLANK_CYCLES    = 4,
  parameter logic        AUTO_DEFAULT    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next,
  input  logic       key_mode,
  input  logic [3:0] page_valid,
  input  logic       freeze,
  output logic [1:0] sel,
  output logic       blank,
  output logic       page_change,
  output logic       auto_mode
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned BL_W = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned NKEY = 2;

  typedef enum logic [1:0] {SHOW, BLANK, NOPAGE} state_t;

  // Key conditioning: bit 0 = next, bit 1 = mode
  logic [NKEY-1:0] key_raw;
  logic [NKEY-1:0] sync1;
  logic [NKEY-1:0] sync2;
  logic [NKEY-1:0] deb;
  logic [NKEY-1:0] deb_d;
  logic [NKEY-1:0] press;
  logic [DB_W-1:0] deb_cnt [NKEY];

  assign key_raw = {key_mode, key_next};

  // 2-FF synchronizer, debouncer and registered falling-edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      press <= '0;
      for (int i = 0; i < int'(NKEY); i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb_d & ~deb;
      for (int i = 0; i < int'(NKEY); i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Returns {found, index} of the first valid page after cur, cyclically
  function automatic logic [2:0] find_next(input logic [1:0] cur, input logic [3:0] valid);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (valid[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [1:0] lowest_valid(input logic [3:0] valid);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid[i]) r = 2'(i);
    end
    return r;
  endfunction

  state_t          state, state_nxt;
  logic [1:0]      sel_q, sel_nxt;
  logic            blank_q, blank_nxt;
  logic            pc_q, pc_nxt;
  logic            auto_q, auto_nxt;
  logic            pending, pend_nxt;
  logic [DW_W-1:0] dwell, dwell_nxt;
  logic [BL_W-1:0] bcnt, bcnt_nxt;
  logic [2:0]      next_c;
  logic [1:0]      low_c;
  logic            expire_c;
  logic            req_c;

  assign next_c   = find_next(sel_q, page_valid);
  assign low_c    = lowest_valid(page_valid);
  assign expire_c = auto_q && !freeze && (dwell == DW_W'(DWELL_CYCLES - 1));

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SHOW;
      sel_q   <= 2'd0;
      blank_q <= 1'b0;
      pc_q    <= 1'b0;
      auto_q  <= AUTO_DEFAULT;
      pending <= 1'b0;
      dwell   <= '0;
      bcnt    <= '0;
    end else begin
      state   <= state_nxt;
      sel_q   <= sel_nxt;
      blank_q <= blank_nxt;
      pc_q    <= pc_nxt;
      auto_q  <= auto_nxt;
      pending <= pend_nxt;
      dwell   <= dwell_nxt;
      bcnt    <= bcnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    pc_nxt    = 1'b0;
    auto_nxt  = auto_q;
    pend_nxt  = pending;
    dwell_nxt = dwell;
    bcnt_nxt  = bcnt;
    req_c     = 1'b0;

    if (page_valid == 4'h0) begin
      // No selectable page: hold sel, drop any pending press
      state_nxt = NOPAGE;
      pend_nxt  = 1'b0;
      bcnt_nxt  = '0;
    end else begin
      case (state)
        SHOW: begin
          req_c    = press[0] | pending | expire_c | ~page_valid[sel_q];
          pend_nxt = 1'b0;
          if (req_c) begin
            // A request clears the dwell even when no other page is valid
            dwell_nxt = '0;
            if (next_c[2]) begin
              sel_nxt   = next_c[1:0];
              pc_nxt    = 1'b1;
              state_nxt = BLANK;
              bcnt_nxt  = '0;
            end
          end else if (auto_q && !freeze) begin
            dwell_nxt = dwell + DW_W'(1);
          end
        end
        BLANK: begin
          if (press[0]) pend_nxt = 1'b1;
          if (bcnt == BL_W'(BLANK_CYCLES - 1)) begin
            state_nxt = SHOW;
            bcnt_nxt  = '0;
          end else begin
            bcnt_nxt = bcnt + BL_W'(1);
          end
        end
        NOPAGE: begin
          if (low_c != sel_q) begin
            sel_nxt = low_c;
            pc_nxt  = 1'b1;
          end
          state_nxt = BLANK;
          bcnt_nxt  = '0;
          dwell_nxt = '0;
        end
        default: state_nxt = SHOW;
      endcase
    end

    // Mode press applies alongside any advance in the same cycle
    if (press[1]) begin
      auto_nxt  = ~auto_q;
      dwell_nxt = '0;
    end
  end

  assign blank_nxt   = (state_nxt != SHOW);
  assign sel         = sel_q;
  assign blank       = blank_q;
  assign page_change = pc_q;
  assign auto_mode   = auto_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Bench for display_page_scheduler: two instances, one with short blanking
// for latency/rotation/skip tests, one with long blanking for pending-press
// and mid-blank reset tests. Expected sel values per page_change are queued.
module tb_display_page_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       key_next1, key_mode1, freeze1;
  logic [3:0] pv1;
  logic [1:0] sel1;
  logic       blank1, pc1, auto1;
  logic       key_next2, key_mode2, freeze2;
  logic [3:0] pv2;
  logic [1:0] sel2;
  logic       blank2, pc2, auto2;

  display_page_scheduler #(
    .DEBOUNCE_CYCLES(4), .DWELL_CYCLES(10), .BLANK_CYCLES(2), .AUTO_DEFAULT(1'b0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_next(key_next1), .key_mode(key_mode1),
    .page_valid(pv1), .freeze(freeze1), .sel(sel1), .blank(blank1),
    .page_change(pc1), .auto_mode(auto1)
  );

  display_page_scheduler #(
    .DEBOUNCE_CYCLES(2), .DWELL_CYCLES(1000), .BLANK_CYCLES(40), .AUTO_DEFAULT(1'b0)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .key_next(key_next2), .key_mode(key_mode2),
    .page_valid(pv2), .freeze(freeze2), .sel(sel2), .blank(blank2),
    .page_change(pc2), .auto_mode(auto2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pc1_cnt = 0;
  int pc2_cnt = 0;
  int blank1_cnt = 0;
  logic [1:0] q1[$];
  logic [1:0] q2[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = next1, 1 = mode1, 2 = next2
  task automatic press_key(input int which, input int lo, input int hi);
    case (which)
      0: key_next1 = 1'b0;
      1: key_mode1 = 1'b0;
      default: key_next2 = 1'b0;
    endcase
    tick(lo);
    case (which)
      0: key_next1 = 1'b1;
      1: key_mode1 = 1'b1;
      default: key_next2 = 1'b1;
    endcase
    tick(hi);
  endtask

  task automatic wait_pc(input int which, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      tick(1);
      n++;
      hit = (which == 1) ? pc1 : pc2;
    end
    if (!hit) check($sformatf("pc%0d_timeout", which), 32'(hit), 32'(1));
  endtask

  // Scoreboard: each page_change pops the expected new sel
  always @(negedge clk) begin
    if (pc1 === 1'b1) begin
      pc1_cnt++;
      if (q1.size() == 0) check("pc1_extra", 32'(pc1), 32'(0));
      else begin
        check("pc1_sel", 32'(sel1), 32'(q1[0]));
        check("pc1_blank", 32'(blank1), 32'(1));
        void'(q1.pop_front());
      end
    end
    if (blank1 === 1'b1) blank1_cnt++;
    if (pc2 === 1'b1) begin
      pc2_cnt++;
      if (q2.size() == 0) check("pc2_extra", 32'(pc2), 32'(0));
      else begin
        check("pc2_sel", 32'(sel2), 32'(q2[0]));
        check("pc2_blank", 32'(blank2), 32'(1));
        void'(q2.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pc_snap, bl_snap;
    rst_n = 1'b0;
    key_next1 = 1'b1; key_mode1 = 1'b1; freeze1 = 1'b0; pv1 = 4'hF;
    key_next2 = 1'b1; key_mode2 = 1'b1; freeze2 = 1'b0; pv2 = 4'hF;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_sel", 32'(sel1), 32'(0));
    check("rst_blank", 32'(blank1), 32'(0));
    check("rst_pc", 32'(pc1), 32'(0));
    check("rst_auto", 32'(auto1), 32'(0));

    // Glitch shorter than the debounce window
    key_next1 = 1'b0;
    tick(3);
    key_next1 = 1'b1;
    tick(20);
    check("glitch_sel", 32'(sel1), 32'(0));
    check("glitch_pc_cnt", 32'(pc1_cnt), 32'(0));

    // Held press: sel changes on the 8th edge after driving low
    q1.push_back(2'd1);
    key_next1 = 1'b0;
    tick(7);
    check("lat_sel_early", 32'(sel1), 32'(0));
    check("lat_blank_early", 32'(blank1), 32'(0));
    tick(1);
    check("lat_sel", 32'(sel1), 32'(1));
    check("lat_pc", 32'(pc1), 32'(1));
    check("lat_blank", 32'(blank1), 32'(1));
    tick(1);
    check("lat_pc_off", 32'(pc1), 32'(0));
    check("lat_blank2", 32'(blank1), 32'(1));
    tick(1);
    check("lat_blank_end", 32'(blank1), 32'(0));
    key_next1 = 1'b1;
    tick(12);

    // Auto rotate
    q1.push_back(2'd2); q1.push_back(2'd3); q1.push_back(2'd0); q1.push_back(2'd1);
    press_key(1, 10, 10);
    check("auto_on", 32'(auto1), 32'(1));
    wait_pc(1, 30, n);
    check("auto_sel3", 32'(sel1), 32'(3));
    wait_pc(1, 30, n);
    check("auto_period", 32'(n), 32'(12));
    check("auto_sel0", 32'(sel1), 32'(0));
    tick(2);
    freeze1 = 1'b1;
    tick(20);
    freeze1 = 1'b0;
    wait_pc(1, 40, n);
    check("freeze_rest", 32'(n), 32'(10));
    check("freeze_sel1", 32'(sel1), 32'(1));

    // Forced advance: current page becomes invalid in SHOW
    tick(2);
    q1.push_back(2'd0);
    pv1 = 4'b0001;
    tick(1);
    check("forced_sel", 32'(sel1), 32'(0));
    check("forced_pc", 32'(pc1), 32'(1));
    tick(2);

    // Single valid page: press and dwell expiry are dropped
    pc_snap = pc1_cnt;
    bl_snap = blank1_cnt;
    press_key(0, 10, 10);
    tick(30);
    check("single_sel", 32'(sel1), 32'(0));
    check("single_pc", 32'(pc1_cnt - pc_snap), 32'(0));
    check("single_blank", 32'(blank1_cnt - bl_snap), 32'(0));
    press_key(1, 10, 10);
    check("auto_off", 32'(auto1), 32'(0));

    // Skip invalid pages
    pv1 = 4'b1001;
    q1.push_back(2'd3);
    press_key(0, 10, 10);
    check("skip_sel3", 32'(sel1), 32'(3));
    q1.push_back(2'd0);
    press_key(0, 10, 10);
    check("skip_sel0", 32'(sel1), 32'(0));

    // No valid page, then a single page returns
    pv1 = 4'h0;
    tick(1);
    check("nopage_blank", 32'(blank1), 32'(1));
    check("nopage_sel", 32'(sel1), 32'(0));
    check("nopage_pc", 32'(pc1), 32'(0));
    tick(5);
    check("nopage_hold", 32'(blank1), 32'(1));
    q1.push_back(2'd2);
    pv1 = 4'b0100;
    tick(1);
    check("exit_sel", 32'(sel1), 32'(2));
    check("exit_pc", 32'(pc1), 32'(1));
    check("exit_blank", 32'(blank1), 32'(1));
    tick(1);
    check("exit_blank2", 32'(blank1), 32'(1));
    tick(1);
    check("exit_show", 32'(blank1), 32'(0));
    pv1 = 4'hF;
    tick(2);

    // Two presses during a long blank: one extra advance in first SHOW cycle
    pc_snap = pc2_cnt;
    q2.push_back(2'd1); q2.push_back(2'd2);
    press_key(2, 6, 6);
    check("b2_blank", 32'(blank2), 32'(1));
    press_key(2, 6, 6);
    press_key(2, 6, 6);
    tick(10);
    wait_pc(2, 30, n);
    check("pend_latency", 32'(n), 32'(1));
    check("pend_sel", 32'(sel2), 32'(2));
    tick(60);
    check("pend_count", 32'(pc2_cnt - pc_snap), 32'(2));
    check("pend_final_sel", 32'(sel2), 32'(2));

    // Reset mid-blank with a pending press
    q2.push_back(2'd3);
    press_key(2, 6, 6);
    press_key(2, 6, 6);
    check("pre_rst_blank", 32'(blank2), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_sel", 32'(sel2), 32'(0));
    check("rst_mid_blank", 32'(blank2), 32'(0));
    check("rst_mid_sel1", 32'(sel1), 32'(0));
    tick(2);
    rst_n = 1'b1;
    pc_snap = pc2_cnt;
    tick(60);
    check("post_rst_sel", 32'(sel2), 32'(0));
    check("post_rst_blank", 32'(blank2), 32'(0));
    check("post_rst_pc", 32'(pc2_cnt - pc_snap), 32'(0));

    check("q1_empty", 32'(q1.size()), 32'(0));
    check("q2_empty", 32'(q2.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_page_scheduler.md
# display_page_scheduler

Sequences the four-page seven-segment display mux: produces its 2-bit page select from debounced front-panel pushbuttons or an auto-rotate dwell timer. Pages marked invalid are skipped, and the display is blanked for a short settle window on every page change. Sits between the board keys and the display page mux, in the display clock domain of the IQ demodulator top level.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level (10 ms at 50 MHz); ≥1.
- DWELL_CYCLES, 100000000: cycles each page is shown in auto mode (2 s at 50 MHz); ≥1.
- BLANK_CYCLES, 4: blanking cycles per page change; ≥1.
- AUTO_DEFAULT, 1'b0: auto_mode value after reset.

- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- key_next  in  1  raw pushbutton, active-low, asynchronous; press = manual advance.
- key_mode  in  1  raw pushbutton, active-low, asynchronous; press = toggle auto_mode.
- page_valid  in  4  bit i high = page i selectable; synchronous to clk.
- freeze  in  1  high pauses the dwell counter (auto mode holds the current page).
- sel  out  2  page select to the display mux.
- blank  out  1  high = display drivers must be forced off.
- page_change  out  1  one-cycle pulse when sel changes.
- auto_mode  out  1  1 = auto-rotate, 0 = manual.

## Operation
- Keys: each key passes through a 2-FF synchronizer, then a debouncer. The debounced level updates only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Press event: a one-cycle pulse on a debounced 1→0 transition. A release generates nothing.
- mode press toggles auto_mode and clears the dwell counter.
- Advance request sources:
  - a next press, in either mode;
  - dwell expiry: auto_mode=1, state SHOW, freeze=0, counter reaches DWELL_CYCLES-1;
  - forced: state SHOW and page_valid[sel]=0.
- Next page: the first index after sel, cyclically (sel+1, sel+2, sel+3 mod 4), whose page_valid bit is set. If no other page is valid, the request is dropped; there is no blank and no pulse.
- FSM states: SHOW, BLANK, NOPAGE.
  - SHOW: blank=0. On an accepted request: sel←next page, page_change=1 for one cycle, dwell counter←0, go to BLANK.
  - BLANK: blank=1 for exactly BLANK_CYCLES cycles, then SHOW. The dwell counter holds. One next press during BLANK is latched as pending and serviced in the first SHOW cycle; further presses are discarded.
  - NOPAGE: entered from any state when page_valid==0. blank=1, sel held. Exits when page_valid≠0; sel←lowest valid index (page_change pulses only if sel changes), then BLANK.
- Simultaneous next press and dwell expiry produce a single advance. Any request clears the dwell counter.
- A mode press in the same cycle as an advance applies both.

## Timing
- Reset values (async): sel=0, blank=0, page_change=0, auto_mode=AUTO_DEFAULT, state SHOW, all counters 0, synchronizers and debounced levels =1 (released), pending=0.
- Reset deasserted mid-BLANK returns directly to SHOW with sel=0; no pending press survives.
- Key latency: with the key held low and stable from sample cycle t, the press pulse occurs at t+2+DEBOUNCE_CYCLES. sel, page_change and blank all update at t+3+DEBOUNCE_CYCLES.
- Auto rotation period: DWELL_CYCLES SHOW cycles plus BLANK_CYCLES blank cycles.
- Forced advance: sel changes on the cycle after page_valid[sel] is seen low in SHOW.
- All outputs are registered. sel changes only in the same cycle as page_change=1 and blank=1.
- Counter widths are $clog2(param+1). The counters saturate and do not wrap.

## Test plan
- Reset and debounce (DEBOUNCE_CYCLES=4, BLANK_CYCLES=2, page_valid=4'hF):
  - key_next low for 3 cycles, then high → no change.
  - key_next held low → sel 0→1 at t+7, page_change one pulse, blank high 2 cycles.
- Auto rotate (DWELL_CYCLES=10): mode press → auto_mode=1; sel steps 1→2→3→0 every 12 cycles. freeze high for 20 cycles → period extends by 20.
- Skip invalid pages: page_valid=4'b1001, sel=0, next press → sel=3; next press → sel=0.
- Forced advance and no-valid pages:
  - page_valid[sel] dropped in SHOW → next valid page one cycle later.
  - page_valid=0 → blank=1 held.
  - page_valid=4'b0100 → sel=2, then BLANK, then SHOW.
- Single valid page: page_valid=4'b0001, next press and dwell expiry → sel stays 0, no page_change, blank stays 0.
- Press during BLANK: two presses inside the blank window → exactly one extra advance after SHOW resumes. rst_n low mid-BLANK → sel=0, blank=0 immediately.
